// File: rtl/seq_pkg.sv
//==============================================================================
// Module      : seq_pkg
// Description : Shared types for the IF/ID/EX/WB control sequencer: state
//               encoding, recognised opcodes and the decoded-control struct.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALTED    = 3'd5
  } seq_state_e;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_LCONST = 6'b001111;
  localparam logic [5:0] OP_HALT   = 6'b111111;

  typedef struct packed {
    logic alu_src;
    logic alu_to_reg;
    logic writes_reg;
    logic is_halt;
    logic is_illegal;
  } seq_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/seq_opcode_decoder.sv
//==============================================================================
// Module      : seq_opcode_decoder
// Description : Combinational opcode-to-control map used by the sequencer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module seq_opcode_decoder
  import seq_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode,
  output seq_ctrl_t           ctrl
);

  always_comb begin
    ctrl = '0;
    if (opcode == OPCODE_W'(OP_RTYPE)) begin
      ctrl.alu_to_reg = 1'b1;
      ctrl.writes_reg = 1'b1;
    end else if (opcode == OPCODE_W'(OP_ADDI)) begin
      ctrl.alu_src    = 1'b1;
      ctrl.alu_to_reg = 1'b1;
      ctrl.writes_reg = 1'b1;
    end else if (opcode == OPCODE_W'(OP_LCONST)) begin
      ctrl.alu_src    = 1'b1;
      ctrl.writes_reg = 1'b1;
    end else if (opcode == OPCODE_W'(OP_HALT)) begin
      ctrl.is_halt    = 1'b1;
    end else begin
      ctrl.is_illegal = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/datapath_sequencer.sv
//==============================================================================
// Module      : datapath_sequencer
// Description : Multi-cycle IF/ID/EX/WB control sequencer with retired count.
//               Optional macro SEQ_PERF_CNT_EN adds a saturating stall_count.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module datapath_sequencer
  import seq_pkg::*;
#(
  parameter int EX_CYCLES = 1,
  parameter int OPCODE_W  = 6,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                step_req,
  input  logic                imem_ready,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                ir_load,
  output logic                alu_src,
  output logic                alu_to_reg,
  output logic                reg_write,
  output logic                pc_inc,
  output logic                busy,
  output logic                halted,
  output logic                illegal_op,
  output logic [2:0]          state_o,
  output logic [CNT_W-1:0]    retired_count
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    stall_count
`endif
);

  localparam int EX_W = 4;

  seq_state_e          state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [EX_W-1:0]     ex_cnt_q, ex_cnt_d;
  logic                alu_src_q, alu_src_d;
  logic                alu_to_reg_q, alu_to_reg_d;
  logic                reg_write_q, reg_write_d;
  logic                pc_inc_q, pc_inc_d;
  logic                busy_q, busy_d;
  logic                halted_q, halted_d;
  logic                illegal_op_q, illegal_op_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  seq_ctrl_t           ctrl;

  // The decoder looks at the opcode the instruction register will hold next,
  // so registered outputs can be formed one cycle ahead of their state.
  assign opcode_d = (state_q == ST_FETCH && imem_ready) ? opcode : opcode_q;

  seq_opcode_decoder #(
    .OPCODE_W (OPCODE_W)
  ) u_decoder (
    .opcode (opcode_d),
    .ctrl   (ctrl)
  );

  always_comb begin
    state_d      = state_q;
    ex_cnt_d     = ex_cnt_q;
    alu_src_d    = alu_src_q;
    alu_to_reg_d = alu_to_reg_q;
    retired_d    = retired_q;
    case (state_q)
      ST_IDLE: begin
        if (run || step_req) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (ctrl.is_halt) begin
          state_d = ST_HALTED;
        end else if (ctrl.is_illegal) begin
          state_d = ST_WRITEBACK;
        end else begin
          alu_src_d    = ctrl.alu_src;
          alu_to_reg_d = ctrl.alu_to_reg;
          ex_cnt_d     = EX_W'(EX_CYCLES - 1);
          state_d      = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (ex_cnt_q == '0) state_d = ST_WRITEBACK;
        else                ex_cnt_d = ex_cnt_q - EX_W'(1);
      end
      ST_WRITEBACK: begin
        if (ctrl.writes_reg) retired_d = retired_q + CNT_W'(1);
        state_d = run ? ST_FETCH : ST_IDLE;
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d       = (state_d == ST_FETCH) || (state_d == ST_DECODE) ||
                   (state_d == ST_EXECUTE) || (state_d == ST_WRITEBACK);
    halted_d     = (state_d == ST_HALTED);
    pc_inc_d     = (state_d == ST_WRITEBACK);
    reg_write_d  = (state_d == ST_WRITEBACK) && ctrl.writes_reg;
    illegal_op_d = (state_d == ST_DECODE) && ctrl.is_illegal;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      opcode_q     <= '0;
      ex_cnt_q     <= '0;
      alu_src_q    <= 1'b0;
      alu_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      pc_inc_q     <= 1'b0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
      illegal_op_q <= 1'b0;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      ex_cnt_q     <= ex_cnt_d;
      alu_src_q    <= alu_src_d;
      alu_to_reg_q <= alu_to_reg_d;
      reg_write_q  <= reg_write_d;
      pc_inc_q     <= pc_inc_d;
      busy_q       <= busy_d;
      halted_q     <= halted_d;
      illegal_op_q <= illegal_op_d;
      retired_q    <= retired_d;
    end
  end

  // The fetch handshake must complete in the same cycle memory is ready.
  assign ir_load       = (state_q == ST_FETCH) && imem_ready;
  assign alu_src       = alu_src_q;
  assign alu_to_reg    = alu_to_reg_q;
  assign reg_write     = reg_write_q;
  assign pc_inc        = pc_inc_q;
  assign busy          = busy_q;
  assign halted        = halted_q;
  assign illegal_op    = illegal_op_q;
  assign state_o       = state_q;
  assign retired_count = retired_q;

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == ST_FETCH && !imem_ready && stall_q != '1)
      stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_count = stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_datapath_sequencer.sv
//==============================================================================
// Module      : tb_datapath_sequencer
// Description : Directed and randomized checks of datapath_sequencer (two
//               configurations) against an instruction-level reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_datapath_sequencer;

  localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3, P_WB = 4, P_HALT = 5;
  localparam int EXC [2] = '{1, 3};
  localparam int CW  [2] = '{16, 4};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, run, step_req, imem_ready;
  logic [5:0] opcode;

  logic        a_ir_load, a_alu_src, a_alu_to_reg, a_reg_write, a_pc_inc;
  logic        a_busy, a_halted, a_illegal_op;
  logic [2:0]  a_state;
  logic [15:0] a_retired;
  logic        b_ir_load, b_alu_src, b_alu_to_reg, b_reg_write, b_pc_inc;
  logic        b_busy, b_halted, b_illegal_op;
  logic [2:0]  b_state;
  logic [3:0]  b_retired;
`ifdef SEQ_PERF_CNT_EN
  logic [15:0] a_stall;
  logic [3:0]  b_stall;
`endif

  datapath_sequencer #(.EX_CYCLES(1), .OPCODE_W(6), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .run(run), .step_req(step_req),
    .imem_ready(imem_ready), .opcode(opcode), .ir_load(a_ir_load),
    .alu_src(a_alu_src), .alu_to_reg(a_alu_to_reg), .reg_write(a_reg_write),
    .pc_inc(a_pc_inc), .busy(a_busy), .halted(a_halted),
    .illegal_op(a_illegal_op), .state_o(a_state), .retired_count(a_retired)
`ifdef SEQ_PERF_CNT_EN
    , .stall_count(a_stall)
`endif
  );

  datapath_sequencer #(.EX_CYCLES(3), .OPCODE_W(6), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .run(run), .step_req(step_req),
    .imem_ready(imem_ready), .opcode(opcode), .ir_load(b_ir_load),
    .alu_src(b_alu_src), .alu_to_reg(b_alu_to_reg), .reg_write(b_reg_write),
    .pc_inc(b_pc_inc), .busy(b_busy), .halted(b_halted),
    .illegal_op(b_illegal_op), .state_o(b_state), .retired_count(b_retired)
`ifdef SEQ_PERF_CNT_EN
    , .stall_count(b_stall)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic cmp(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit op_valid(input int op);
    return (op == 0) || (op == 8) || (op == 15);
  endfunction

  // Reference model: one record per configuration, advanced per clock edge.
  int m_ph [2], m_op [2], m_ex [2], m_src [2], m_tor [2], m_ret [2], m_stall [2];
  initial for (int k = 0; k < 2; k++) begin
    m_ph[k] = 0; m_op[k] = 0; m_ex[k] = 0; m_src[k] = 0;
    m_tor[k] = 0; m_ret[k] = 0; m_stall[k] = 0;
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int ph, op, ex, src, tor, ret, st, mask;
      mask = (1 << CW[k]) - 1;
      ph = m_ph[k]; op = m_op[k]; ex = m_ex[k]; src = m_src[k];
      tor = m_tor[k]; ret = m_ret[k]; st = m_stall[k];
      if (reset) begin
        ph = P_IDLE; op = 0; ex = 0; src = 0; tor = 0; ret = 0; st = 0;
      end else begin
        if (ph == P_FETCH && !imem_ready && st < mask) st = st + 1;
        case (ph)
          P_IDLE:   if (run || step_req) ph = P_FETCH;
          P_FETCH:  if (imem_ready) begin op = int'(opcode); ph = P_DECODE; end
          P_DECODE: begin
            if (op == 63) ph = P_HALT;
            else if (op_valid(op)) begin
              src = (op != 0); tor = (op != 15); ex = EXC[k]; ph = P_EXEC;
            end else ph = P_WB;
          end
          P_EXEC: begin
            ex = ex - 1;
            if (ex == 0) ph = P_WB;
          end
          P_WB: begin
            if (op_valid(op)) ret = (ret + 1) & mask;
            ph = run ? P_FETCH : P_IDLE;
          end
          default: ph = ph;
        endcase
      end
      m_ph[k] <= ph; m_op[k] <= op; m_ex[k] <= ex; m_src[k] <= src;
      m_tor[k] <= tor; m_ret[k] <= ret; m_stall[k] <= st;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        bit wb, ir;
        wb = (m_ph[k] == P_WB);
        ir = (m_ph[k] == P_FETCH) && imem_ready;
        cmp($sformatf("ir_load[%0d]", k),    k ? b_ir_load : a_ir_load, ir);
        cmp($sformatf("alu_src[%0d]", k),    k ? b_alu_src : a_alu_src, m_src[k]);
        cmp($sformatf("alu_to_reg[%0d]", k), k ? b_alu_to_reg : a_alu_to_reg, m_tor[k]);
        cmp($sformatf("reg_write[%0d]", k),  k ? b_reg_write : a_reg_write, wb && op_valid(m_op[k]));
        cmp($sformatf("pc_inc[%0d]", k),     k ? b_pc_inc : a_pc_inc, wb);
        cmp($sformatf("busy[%0d]", k),       k ? b_busy : a_busy, m_ph[k] >= P_FETCH && m_ph[k] <= P_WB);
        cmp($sformatf("halted[%0d]", k),     k ? b_halted : a_halted, m_ph[k] == P_HALT);
        cmp($sformatf("illegal_op[%0d]", k), k ? b_illegal_op : a_illegal_op,
            m_ph[k] == P_DECODE && !op_valid(m_op[k]) && m_op[k] != 63);
        cmp($sformatf("state_o[%0d]", k),    k ? b_state : a_state, m_ph[k]);
        cmp($sformatf("retired[%0d]", k),    k ? b_retired : a_retired, m_ret[k]);
`ifdef SEQ_PERF_CNT_EN
        cmp($sformatf("stall[%0d]", k),      k ? b_stall : a_stall, m_stall[k]);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; step_req = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int r, cnt;
    reset = 1'b1; run = 1'b0; step_req = 1'b0; imem_ready = 1'b1; opcode = 6'd0;
    tick(); tick();
    chk_en = 1'b1;
    reset = 1'b0;

    // Single step, EX_CYCLES = 1: ir_load cycle 1, writeback cycle 4.
    cmp("rst_state", a_state, 0);
    cmp("rst_retired", a_retired, 0);
    cmp("rst_reg_write", a_reg_write, 0);
    step_req = 1'b1; tick(); step_req = 1'b0;
    cmp("step_ir_load_c1", a_ir_load, 1);
    tick(); tick(); tick();
    cmp("step_reg_write_c4", a_reg_write, 1);
    cmp("step_pc_inc_c4", a_pc_inc, 1);
    tick();
    cmp("step_retired_c5", a_retired, 1);
    cmp("step_idle_c5", a_state, 0);

    // Memory stall of 5 cycles in FETCH.
    do_reset();
    imem_ready = 1'b0; step_req = 1'b1; tick(); step_req = 1'b0;
    repeat (5) tick();
    cmp("stall_no_ir_load", a_ir_load, 0);
    imem_ready = 1'b1; tick();
`ifdef SEQ_PERF_CNT_EN
    cmp("stall_count_a", a_stall, 5);
    cmp("stall_count_b", b_stall, 5);
`endif
    repeat (10) tick();

    // HALT is absorbing.
    do_reset();
    opcode = 6'b111111; step_req = 1'b1; tick(); step_req = 1'b0;
    tick(); tick();
    cmp("halt_halted", a_halted, 1);
    cmp("halt_state", a_state, 5);
    cmp("halt_busy", a_busy, 0);
    run = 1'b1;
    repeat (6) begin step_req = 1'b1; tick(); step_req = 1'b0; end
    cmp("halt_sticky", a_state, 5);
    cmp("halt_sticky_b", b_halted, 1);
    cmp("halt_no_retire", a_retired, 0);

    // Illegal opcode: pulse, pc_inc without reg_write, no retire.
    do_reset();
    opcode = 6'b010101; step_req = 1'b1; tick(); step_req = 1'b0;
    tick();
    cmp("illegal_pulse", a_illegal_op, 1);
    tick();
    cmp("illegal_pc_inc", a_pc_inc, 1);
    cmp("illegal_no_write", a_reg_write, 0);
    tick();
    cmp("illegal_retired", a_retired, 0);
    cmp("illegal_pulse_end", a_illegal_op, 0);

    // Reset during EXECUTE (config B is in EXECUTE at cycle 3).
    do_reset();
    opcode = 6'd0; step_req = 1'b1; tick(); step_req = 1'b0;
    tick(); tick();
    cmp("mid_exec_state", b_state, 3);
    reset = 1'b1; tick(); reset = 1'b0;
    cmp("mid_rst_state", b_state, 0);
    cmp("mid_rst_busy", b_busy, 0);
    cmp("mid_rst_alu_to_reg", b_alu_to_reg, 0);
    cmp("mid_rst_retired", b_retired, 0);

    // Drop run during DECODE: instruction completes, parks in IDLE.
    opcode = 6'b001000; run = 1'b1; tick(); tick();
    run = 1'b0; tick(); tick(); tick();
    cmp("run_drop_state", a_state, 0);
    cmp("run_drop_retired", a_retired, 1);
    cmp("run_drop_alu_src", a_alu_src, 1);
    repeat (10) tick();

    // Counter wrap on the 4-bit configuration: 17 instructions -> 1.
    do_reset();
    opcode = 6'd0; run = 1'b1; cnt = 0;
    for (int i = 0; i < 300 && cnt < 17; i++) begin
      tick();
      if (b_reg_write) cnt++;
      if (cnt == 17) run = 1'b0;
    end
    cmp("wrap_instr_count", cnt, 17);
    repeat (8) tick();
    cmp("wrap_retired_b", b_retired, 1);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(99) < 5) run = ~run;
      step_req   = ($urandom_range(7) == 0);
      imem_ready = ($urandom_range(99) < 75);
      r = $urandom_range(19);
      if (r < 5)       opcode = 6'd0;
      else if (r < 10) opcode = 6'b001000;
      else if (r < 15) opcode = 6'b001111;
      else if (r < 18) opcode = 6'($urandom);
      else if (r == 18) opcode = 6'b111111;
      else             opcode = 6'd0;
      reset = ($urandom_range(299) == 0) ||
              (a_halted && b_halted && $urandom_range(9) == 0);
      tick();
    end
    reset = 1'b0; run = 1'b0; step_req = 1'b0;
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
Multi-cycle control sequencer for the IF/ID/EX/WB datapath.
- Steps the datapath through one phase per state, drives the datapath control signals, and counts retired instructions.
- Gates the instruction-register load, register-file write and PC increment so that exactly one instruction completes per pass.
- Supports free-run and single-step operation, plus a terminal HALT.

Parameters:
EX_CYCLES, 1, cycles spent in EXECUTE; legal range 1..15.
OPCODE_W, 6, width of the instruction opcode field (instruction[31:26]).
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
run  input  1  level; while high, instructions execute back-to-back.
step_req  input  1  one-cycle pulse; in IDLE, executes exactly one instruction.
imem_ready  input  1  instruction memory has valid data this cycle.
opcode  input  OPCODE_W  opcode of the instruction currently on the fetch bus.
ir_load  output  1  load the instruction register (fetch handshake).
alu_src  output  1  to EX: 1 selects the constant, 0 selects data2.
alu_to_reg  output  1  to WB: 1 writes the ALU result, 0 writes the extended constant.
reg_write  output  1  register-file write enable (one-cycle pulse).
pc_inc  output  1  PC advance (one-cycle pulse).
busy  output  1  high in FETCH, DECODE, EXECUTE and WRITEBACK.
halted  output  1  high in HALTED.
illegal_op  output  1  one-cycle pulse when an opcode is not recognised.
state_o  output  3  current state encoding.
retired_count  output  CNT_W  number of instructions that completed WRITEBACK.

Behaviour:
- Reset: synchronous, active-high. Takes priority over every other input and applies mid-instruction. Returns to IDLE; all outputs 0; retired_count = 0.
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALTED.
- IDLE:
  - Moves to FETCH if run = 1 or step_req = 1.
  - If both are high, run wins; behaviour is the same either way.
- FETCH:
  - Waits indefinitely while imem_ready = 0.
  - When imem_ready = 1: ir_load = 1 in that same cycle, opcode is captured into an internal register, and the state moves to DECODE.
- DECODE (one cycle): the captured opcode is decoded.
  - 000000 (R-type): alu_src = 0, alu_to_reg = 1, then EXECUTE.
  - 001000 (ADDI): alu_src = 1, alu_to_reg = 1, then EXECUTE.
  - 001111 (LCONST): alu_src = 1, alu_to_reg = 0, then EXECUTE.
  - 111111 (HALT): go to HALTED; no reg_write, no pc_inc.
  - Any other opcode: illegal_op pulses for one cycle, then go to WRITEBACK with writes suppressed; pc_inc still fires and retired_count does not increment.
- Control registering: alu_src and alu_to_reg are registered at DECODE exit and held until the next DECODE. They return to 0 only on reset.
- EXECUTE: lasts exactly EX_CYCLES cycles, timed by an internal down-counter; then WRITEBACK.
- WRITEBACK (one cycle):
  - Valid instruction: reg_write = 1, pc_inc = 1, and retired_count increments (visible the next cycle).
  - retired_count wraps from 2^CNT_W - 1 to 0 without a flag.
  - Next state is FETCH if run = 1, otherwise IDLE.
- run deasserted mid-instruction: the current instruction completes, and the sequencer stops in IDLE after WRITEBACK.
- step_req outside IDLE is ignored; it is not queued.
- HALTED: absorbing state, left only via reset. halted = 1, busy = 0.
- Latency with zero-wait memory and EX_CYCLES = 1: 4 cycles per instruction. step_req in cycle 0 produces reg_write in cycle 4.

Optional Feature:
SEQ_PERF_CNT_EN
- Defined: adds output stall_count[CNT_W-1:0]. It counts cycles spent in FETCH with imem_ready = 0, clears on reset, saturates at all-ones, and does not wrap.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package seq_pkg holds:
  - the state enumeration (3-bit);
  - opcode constants OP_RTYPE, OP_ADDI, OP_LCONST, OP_HALT;
  - a decoded-control struct {alu_src, alu_to_reg, writes_reg, is_halt, is_illegal}.
- Sub-module seq_opcode_decoder is a purely combinational map from opcode to the control struct, used in DECODE. The FSM, EXECUTE counter and retired counter stay in the top module.

Test Plan:
1. Single step: reset, then step_req at cycle 0 with opcode 000000, imem_ready = 1 → ir_load at cycle 1, reg_write = pc_inc = 1 at cycle 4, retired_count = 1 at cycle 5, return to IDLE.
2. Free run: run = 1, opcodes 001000, 001111, 000000, EX_CYCLES = 3 → 6 cycles per instruction; alu_src/alu_to_reg = 1/1, 1/0, 0/1; retired_count = 3.
3. Memory stall: hold imem_ready = 0 for 5 cycles in FETCH → no ir_load during the stall; with SEQ_PERF_CNT_EN defined, stall_count = 5.
4. HALT and illegal opcode:
   - opcode 111111 → HALTED with halted = 1 and no reg_write; run and step_req are then ignored until reset.
   - opcode 010101 → one illegal_op pulse, pc_inc = 1, reg_write = 0, retired_count unchanged.
5. Reset mid-operation: assert reset during EXECUTE → next cycle is IDLE with all outputs 0 and retired_count = 0. Drop run in DECODE → the instruction finishes and the sequencer parks in IDLE.
6. Counter wrap: CNT_W = 4, run 17 valid instructions → retired_count = 1.
